// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among NUM_REQ functional units, one registered broadcast per cycle.
// Optional CDB_ARB_REDIRECT_PRIO_EN: lowest-index valid redirecting FU wins ahead of round-robin.
module cdb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ROB_DEPTH  = 64,
    localparam int TAG_WIDTH = $clog2(ROB_DEPTH)
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          i_flush,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  i_req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0]            i_req_redirect,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_cdb_en,
    output logic [TAG_WIDTH-1:0]          o_cdb_tag,
    output logic [DATA_WIDTH-1:0]         o_cdb_data,
    output logic [ADDR_WIDTH-1:0]         o_cdb_addr,
    output logic                          o_cdb_redirect
);
    localparam int PTR_WIDTH = $clog2(NUM_REQ);

    logic [TAG_WIDTH-1:0]  tag_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign tag_arr[gi]  = i_req_tag[gi*TAG_WIDTH +: TAG_WIDTH];
            assign data_arr[gi] = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign addr_arr[gi] = i_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    logic [PTR_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
    logic [PTR_WIDTH-1:0] search_idx;
    logic [PTR_WIDTH-1:0] winner;
    logic                 found;
    logic                 grant_valid;

    logic                  cdb_en_reg;
    logic [TAG_WIDTH-1:0]  cdb_tag_reg;
    logic [DATA_WIDTH-1:0] cdb_data_reg;
    logic [ADDR_WIDTH-1:0] cdb_addr_reg;
    logic                  cdb_redirect_reg;

    // Winner search never looks at payload, so ready depends only on valid, pointer and flush.
    always_comb begin
        found      = 1'b0;
        winner     = '0;
        search_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            search_idx = PTR_WIDTH'((int'(rr_ptr_reg) + i) % NUM_REQ);
            if (!found && i_req_valid[search_idx]) begin
                found  = 1'b1;
                winner = search_idx;
            end
        end
`ifdef CDB_ARB_REDIRECT_PRIO_EN
        begin
            logic prio_found;
            prio_found = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!prio_found && i_req_valid[i] && i_req_redirect[i]) begin
                    prio_found = 1'b1;
                    winner     = PTR_WIDTH'(i);
                end
            end
        end
`endif
    end

    assign grant_valid = found && !i_flush && n_rst;
    assign rr_ptr_next = (winner == PTR_WIDTH'(NUM_REQ-1)) ? '0 : winner + 1'b1;

    always_comb begin
        o_req_ready = '0;
        if (grant_valid)
            o_req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rr_ptr_reg       <= '0;
            cdb_en_reg       <= 1'b0;
            cdb_tag_reg      <= '0;
            cdb_data_reg     <= '0;
            cdb_addr_reg     <= '0;
            cdb_redirect_reg <= 1'b0;
        end else if (i_flush) begin
            rr_ptr_reg <= '0;
            cdb_en_reg <= 1'b0;
        end else begin
            cdb_en_reg <= grant_valid;
            if (grant_valid) begin
                rr_ptr_reg       <= rr_ptr_next;
                cdb_tag_reg      <= tag_arr[winner];
                cdb_data_reg     <= data_arr[winner];
                cdb_addr_reg     <= addr_arr[winner];
                cdb_redirect_reg <= i_req_redirect[winner];
            end
        end
    end

    assign o_cdb_en       = cdb_en_reg;
    assign o_cdb_tag      = cdb_tag_reg;
    assign o_cdb_data     = cdb_data_reg;
    assign o_cdb_addr     = cdb_addr_reg;
    assign o_cdb_redirect = cdb_redirect_reg;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, saturation, single request, wrap, flush, redirect priority, mid-stream reset.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int AW = 32;

    logic           clk = 1'b0;
    logic           n_rst;
    logic           flush;
    logic [N-1:0]   valid;
    logic [N-1:0]   redir;
    logic [TW-1:0]  tag  [N];
    logic [DW-1:0]  data [N];
    logic [AW-1:0]  addr [N];
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_data;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]   ready;
    logic           cdb_en;
    logic [TW-1:0]  cdb_tag;
    logic [DW-1:0]  cdb_data;
    logic [AW-1:0]  cdb_addr;
    logic           cdb_redirect;

    int tests = 0;
    int fails = 0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign req_tag[gi*TW +: TW]  = tag[gi];
            assign req_data[gi*DW +: DW] = data[gi];
            assign req_addr[gi*AW +: AW] = addr[gi];
        end
    endgenerate

    cdb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROB_DEPTH(64)) dut (
        .clk(clk), .n_rst(n_rst), .i_flush(flush),
        .i_req_valid(valid), .i_req_tag(req_tag), .i_req_data(req_data),
        .i_req_addr(req_addr), .i_req_redirect(redir),
        .o_req_ready(ready), .o_cdb_en(cdb_en), .o_cdb_tag(cdb_tag),
        .o_cdb_data(cdb_data), .o_cdb_addr(cdb_addr), .o_cdb_redirect(cdb_redirect)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
            else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
            end
        $display("[TB] %s: observed %0h expected %0h", name, obs, exp);
    endtask

    initial begin
        n_rst = 1'b0;
        flush = 1'b0;
        valid = '1;
        redir = '0;
        for (int k = 0; k < N; k++) begin
            tag[k]  = TW'(10 + k);
            data[k] = 32'h1000 + k;
            addr[k] = 32'h40 * (k + 1);
        end
        addr[0] = 32'h40;

        // Reset held with every FU valid
        #1;
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_cdb_en", 64'(cdb_en), 64'h0);
        chk("rst_cdb_tag", 64'(cdb_tag), 64'h0);
        @(posedge clk); #1;
        chk("rst_ready_edge", 64'(ready), 64'h0);

        // Saturation from rr_ptr=0: grants 0,1,2,3,0,1
        @(negedge clk);
        n_rst = 1'b1;
        for (int n = 0; n < 6; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            chk($sformatf("sat_ready_%0d", n), 64'(ready), 64'(4'b0001 << (n % 4)));
            @(posedge clk); #1;
            chk($sformatf("sat_en_%0d", n), 64'(cdb_en), 64'h1);
            chk($sformatf("sat_tag_%0d", n), 64'(cdb_tag), 64'(10 + (n % 4)));
        end

        // Idle: rr_ptr=2
        @(negedge clk);
        valid = '0; #1;
        chk("idle_ready", 64'(ready), 64'h0);
        @(posedge clk); #1;
        chk("idle_en", 64'(cdb_en), 64'h0);

        // Single request on FU2
        @(negedge clk);
        valid = 4'b0100; tag[2] = 6'd5; data[2] = 32'hDEADBEEF; #1;
        chk("single_ready", 64'(ready), 64'h4);
        @(posedge clk); #1;
        chk("single_en", 64'(cdb_en), 64'h1);
        chk("single_tag", 64'(cdb_tag), 64'h5);
        chk("single_data", 64'(cdb_data), 64'hDEADBEEF);
        @(negedge clk);
        valid = '0;
        @(posedge clk); #1;
        chk("single_en_drop", 64'(cdb_en), 64'h0);

        // Wrap: rr_ptr=3, FU0 and FU3 valid
        @(negedge clk);
        valid = 4'b1001; #1;
        chk("wrap_ready3", 64'(ready), 64'h8);
        @(posedge clk); #1;
        chk("wrap_tag3", 64'(cdb_tag), 64'd13);
        @(negedge clk);
        valid = 4'b0001; #1;
        chk("wrap_ready0", 64'(ready), 64'h1);
        @(posedge clk); #1;
        chk("wrap_tag0", 64'(cdb_tag), 64'd10);

        // rr_ptr=1 now: FU1 beats FU0
        @(negedge clk);
        valid = 4'b0011; #1;
        chk("ptr1_ready", 64'(ready), 64'h2);
        @(posedge clk); #1;
        chk("ptr1_tag", 64'(cdb_tag), 64'd11);

        // Flush with FU1 valid; registered beat still visible this cycle
        @(negedge clk);
        valid = 4'b0010; flush = 1'b1; #1;
        chk("flush_ready", 64'(ready), 64'h0);
        chk("flush_inflight_en", 64'(cdb_en), 64'h1);
        @(posedge clk); #1;
        chk("flush_en", 64'(cdb_en), 64'h0);

        // rr_ptr back to 0: FU1 beats FU3
        @(negedge clk);
        flush = 1'b0; valid = 4'b1010; #1;
        chk("postflush_ready", 64'(ready), 64'h2);
        @(posedge clk); #1;
        chk("postflush_en", 64'(cdb_en), 64'h1);
        chk("postflush_tag", 64'(cdb_tag), 64'd11);

        // Flush again to return rr_ptr to 0
        @(negedge clk);
        valid = '0; flush = 1'b1;
        @(posedge clk); #1;
        chk("flush2_en", 64'(cdb_en), 64'h0);

        // Redirect priority check
        @(negedge clk);
        flush = 1'b0; valid = 4'b0101; redir = 4'b0100; addr[2] = 32'h100; #1;
`ifdef CDB_ARB_REDIRECT_PRIO_EN
        chk("redir_ready", 64'(ready), 64'h4);
        @(posedge clk); #1;
        chk("redir_flag", 64'(cdb_redirect), 64'h1);
        chk("redir_addr", 64'(cdb_addr), 64'h100);
`else
        chk("redir_ready", 64'(ready), 64'h1);
        @(posedge clk); #1;
        chk("redir_flag", 64'(cdb_redirect), 64'h0);
        chk("redir_addr", 64'(cdb_addr), 64'h40);
`endif
        chk("redir_en", 64'(cdb_en), 64'h1);

        // Asynchronous reset mid-stream drops the in-flight broadcast
        @(negedge clk);
        n_rst = 1'b0; #1;
        chk("midrst_en", 64'(cdb_en), 64'h0);
        chk("midrst_ready", 64'(ready), 64'h0);
        chk("midrst_tag", 64'(cdb_tag), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
